// File: rtl/heat_sequencer.sv
// Cooking-timer sequencer: IDLE/SET/RUN/PAUSE/DONE with mm:ss countdown and beep.
// Optional door interlock enabled by defining DOOR_INTERLOCK_EN.
module heat_sequencer #(
    parameter int MAX_MIN    = 99,
    parameter int STEP_SEC   = 30,
    parameter int BEEP_TICKS = 3
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic [3:0] Estado,
    input  logic       tick,
    input  logic       inc,
    input  logic       dec,
    input  logic       door_open,
    output logic       heater,
    output logic [6:0] minutes,
    output logic [5:0] seconds,
    output logic       beep,
    output logic [2:0] state_out
);
    typedef enum logic [2:0] {
        IDLE  = 3'b000,
        SET   = 3'b001,
        RUN   = 3'b010,
        PAUSE = 3'b011,
        DONE  = 3'b100
    } state_t;

    localparam logic [3:0] E_ADJ  = 4'b0001;
    localparam logic [3:0] E_HEAT = 4'b0100;
    localparam int         BW     = (BEEP_TICKS > 1) ? $clog2(BEEP_TICKS) : 1;
    localparam logic [BW-1:0] BLAST = BW'(BEEP_TICKS - 1);
    localparam logic [6:0] MAX7   = 7'(MAX_MIN);
    localparam logic [6:0] STEP7  = 7'(STEP_SEC);

    state_t        r_state, w_state_nx;
    logic [6:0]    r_min, w_min_nx;
    logic [5:0]    r_sec, w_sec_nx;
    logic [BW-1:0] r_bcnt, w_bcnt_nx;
    logic          w_door;

`ifdef DOOR_INTERLOCK_EN
    assign w_door = door_open;
`else
    logic w_unused_door;
    assign w_unused_door = door_open;
    assign w_door        = 1'b0;
`endif

    // inc: add STEP with minute carry, then clamp to MAX_MIN:59
    logic [6:0] w_sec_sum;
    logic       w_inc_c;
    logic [7:0] w_min_inc;
    logic [5:0] w_sec_inc;
    logic       w_inc_sat;
    assign w_sec_sum = {1'b0, r_sec} + STEP7;
    assign w_inc_c   = (w_sec_sum >= 7'd60);
    assign w_sec_inc = 6'(w_inc_c ? (w_sec_sum - 7'd60) : w_sec_sum);
    assign w_min_inc = {1'b0, r_min} + {7'd0, w_inc_c};
    assign w_inc_sat = (w_min_inc > {1'b0, MAX7});

    // dec: subtract STEP with minute borrow, clamp at 00:00
    logic       w_borrow;
    logic [5:0] w_sec_dec;
    logic       w_dec_sat;
    assign w_borrow  = ({1'b0, r_sec} < STEP7);
    assign w_sec_dec = 6'(w_borrow ? ({1'b0, r_sec} + 7'd60 - STEP7) : ({1'b0, r_sec} - STEP7));
    assign w_dec_sat = w_borrow && (r_min == 7'd0);

    logic w_time_zero, w_time_one;
    assign w_time_zero = (r_min == 7'd0) && (r_sec == 6'd0);
    assign w_time_one  = (r_min == 7'd0) && (r_sec == 6'd1);

    always_comb begin
        w_state_nx = r_state;
        w_min_nx   = r_min;
        w_sec_nx   = r_sec;
        w_bcnt_nx  = '0;
        case (r_state)
            IDLE: begin
                if (Estado == E_ADJ)
                    w_state_nx = SET;
                else if (Estado == E_HEAT && !w_time_zero && !w_door)
                    w_state_nx = RUN;
            end
            SET: begin
                if (Estado != E_ADJ) begin
                    w_state_nx = IDLE;
                end else if (inc && !dec) begin
                    w_min_nx = w_inc_sat ? MAX7  : w_min_inc[6:0];
                    w_sec_nx = w_inc_sat ? 6'd59 : w_sec_inc;
                end else if (dec && !inc) begin
                    w_min_nx = w_dec_sat ? 7'd0 : r_min - {6'd0, w_borrow};
                    w_sec_nx = w_dec_sat ? 6'd0 : w_sec_dec;
                end
            end
            RUN: begin
                if (w_door || Estado != E_HEAT) begin
                    w_state_nx = PAUSE;
                end else if (tick) begin
                    if (w_time_one || w_time_zero) begin
                        w_state_nx = DONE;
                        w_min_nx   = 7'd0;
                        w_sec_nx   = 6'd0;
                    end else if (r_sec == 6'd0) begin
                        w_min_nx = r_min - 7'd1;
                        w_sec_nx = 6'd59;
                    end else begin
                        w_sec_nx = r_sec - 6'd1;
                    end
                end
            end
            PAUSE: begin
                if (Estado == E_HEAT && !w_door)
                    w_state_nx = RUN;
                else if (Estado == E_ADJ)
                    w_state_nx = SET;
            end
            DONE: begin
                w_min_nx = 7'd0;
                w_sec_nx = 6'd0;
                if (Estado == E_ADJ) begin
                    w_state_nx = SET;
                end else if (tick) begin
                    if (r_bcnt == BLAST) w_state_nx = IDLE;
                    else                 w_bcnt_nx  = r_bcnt + 1'b1;
                end else begin
                    w_bcnt_nx = r_bcnt;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_min   <= '0;
            r_sec   <= '0;
            r_bcnt  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_min   <= w_min_nx;
            r_sec   <= w_sec_nx;
            r_bcnt  <= w_bcnt_nx;
        end
    end

    // Decoded straight from the state register so async reset drops them at once
    assign heater    = (r_state == RUN);
    assign beep      = (r_state == DONE);
    assign minutes   = r_min;
    assign seconds   = r_sec;
    assign state_out = r_state;
endmodule
